true_dpr_be: RTL and testbench
==============================

Name: true_dpr_be

Overview:
- Single-clock true dual-port RAM with per-byte write enables. Each port can read and write.
- Successor to the dual-clock byte-less TDPR. Adds byte lanes, a selectable read-during-write mode, an optional output register, deterministic cross-port collision resolution, read-valid flags and a post-reset memory-clear sequencer.
- Intended as the generic on-chip buffer behind DMA engines and packet FIFOs.

Parameters:
- BYTE_WIDTH, 8: bits per byte lane.
- NUM_BYTES, 4: byte lanes per word. DATA_WIDTH = BYTE_WIDTH*NUM_BYTES.
- ADDR_WIDTH, 8: depth is 2**ADDR_WIDTH words.
- RDW_MODE, 0: same-port read-during-write mode. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0: 1 adds an output register stage, so read latency becomes 2.
- CLEAR_ON_RESET, 1: 1 zeroes every word after reset before accepting accesses.

Ports:
- clk, in, 1: the only clock. Reset is synchronous and active-high, and everything is on one clock.
- rst, in, 1: synchronous active-high reset.
- ready, out, 1: high when ports accept accesses.
- a_en, in, 1: port A access enable.
- a_we, in, NUM_BYTES: port A byte write enables. Qualified by a_en.
- a_addr, in, ADDR_WIDTH: port A address.
- a_data, in, DATA_WIDTH: port A write data.
- a_q, out, DATA_WIDTH: port A read data.
- a_q_valid, out, 1: a_q updated this cycle.
- b_en, b_we, b_addr, b_data, b_q, b_q_valid: identical to the port A signals, for port B.
- collision, out, 1: registered flag for a same-address, same-cycle conflict.

Behaviour:
- Reset (rst=1 at a clk edge):
  - a_q, b_q, a_q_valid, b_q_valid, collision and ready all go to 0.
  - The read pipeline is flushed.
  - The FSM goes to CLEAR if CLEAR_ON_RESET=1, else to READY.
  - Memory contents are untouched by rst itself.
- FSM, state CLEAR:
  - A clear counter of ADDR_WIDTH bits starts at 0.
  - Each cycle, mem[cnt] is written with 0 and cnt increments.
  - On the cycle cnt = 2**ADDR_WIDTH-1, the last word is written and the FSM moves to READY. ready is registered high on that same edge.
  - Total: 2**ADDR_WIDTH cycles after rst falls. ready is low throughout.
- FSM, state READY:
  - ready=1.
  - The FSM stays in READY until rst.
- Access gating: while ready=0, en/we are ignored. No writes, and valid stays 0.
- Access and latency:
  - An access is port en=1 while ready=1.
  - Bytes with we[i]=1 are written at the edge.
  - Read data appears with q_valid=1 exactly 1+OUT_REG cycles after the access edge.
  - Without an access, q holds its last value and q_valid=0.
- Same-port read-during-write:
  - READ_FIRST: q returns the pre-write word.
  - WRITE_FIRST: q returns the merged word, new bytes where we[i]=1 and old bytes elsewhere.
  - NO_CHANGE: an access with any we bit set produces no read. q holds and q_valid=0. Accesses with we=0 read normally.
- Cross-port, same address, same cycle:
  - Both ports writing the same byte: port A wins.
  - Bytes enabled by only one port take that port's data.
  - A port reading while the other port writes gets the pre-write data (read-first cross-port) in every RDW_MODE.
  - collision=1 one cycle after any edge where both ports access, the addresses are equal and at least one we bit is set on either port. Otherwise collision=0.
- rst mid-operation:
  - In-flight reads are dropped and valids go to 0.
  - A pending clear restarts from address 0.
- Width rule: addresses are unsigned and the full range 0..2**ADDR_WIDTH-1 is legal. There is no wrap logic outside the clear counter.

Decomposition:
- Package true_dpr_be_pkg holds:
  - the rdw_mode_t enum (READ_FIRST, WRITE_FIRST, NO_CHANGE);
  - the state_t enum (CLEAR, READY);
  - a byte_merge function (old, new, we) that returns the merged word.
- Sub-module true_dpr_be_rd_port: the per-port read pipeline (RDW select, optional OUT_REG stage, q/q_valid). It is instantiated twice.
- The top level holds the memory array, the write arbitration, the FSM/clear counter and the collision flag.

Test Plan:
All scenarios use BYTE_WIDTH=8, NUM_BYTES=4 and ADDR_WIDTH=4.
1. Clear: preload mem[5]=0xDEADBEEF, pulse rst for 1 cycle → ready=0 for 16 cycles, then 1. A read of addr 5 returns 0x00000000 with a_q_valid one cycle later (OUT_REG=0), or two cycles later with OUT_REG=1.
2. Byte write: mem[3]=0x11223344, A writes a_we=4'b0101, a_data=0xAABBCCDD → a following read returns 0x11BB33DD.
3. RDW: mem[7]=0x01020304, A writes 0xFFFFFFFF with we=4'b1111 and en=1 at addr 7. READ_FIRST gives a_q=0x01020304 with valid=1. WRITE_FIRST gives 0xFFFFFFFF with valid=1. NO_CHANGE gives a_q unchanged with a_q_valid=0.
4. Dual write collision: at addr 2, A writes 0xAAAAAAAA with we=4'b0011 and B writes 0xBBBBBBBB with we=4'b0110 → mem[2]=0x00BBAAAA (from a cleared memory), and collision=1 for exactly one cycle.
5. Cross read/write: mem[9]=0x12345678, A writes 0x0 at addr 9 while B reads addr 9 → b_q=0x12345678 and collision=1. A second B read returns 0x00000000 and collision=0.
6. Reset mid-clear: assert rst at clear count 6 → ready stays low for 16 more cycles after rst falls, and en pulses during the clear cause no write and no valid.

Source files
------------

// File: rtl/true_dpr_be_pkg.sv
// Shared types and helpers for the byte-enabled true dual-port RAM.
// byte_merge works on a fixed maximum width; callers zero-extend and slice.
package true_dpr_be_pkg;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } rdw_mode_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int MAX_BYTE_W = 16;
    localparam int MAX_BYTES  = 16;
    localparam int MAX_DATA_W = 256;

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BYTES-1:0]  we,
        input int                    byte_w
    );
        logic [MAX_DATA_W-1:0] merged;
        logic [7:0]            idx;
        int                    pos;
        merged = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            for (int j = 0; j < MAX_BYTE_W; j++) begin
                pos = i * byte_w + j;
                if (we[i[3:0]] && (j < byte_w) && (pos < MAX_DATA_W)) begin
                    idx         = pos[7:0];
                    merged[idx] = new_word[idx];
                end
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/true_dpr_be_rd_port.sv
// Per-port read pipeline: read-during-write select, optional output stage,
// q holds its last value whenever no read completes.
module true_dpr_be_rd_port
    import true_dpr_be_pkg::*;
#(
    parameter int  BYTE_WIDTH = 8,
    parameter int  NUM_BYTES  = 4,
    parameter int  RDW_MODE   = 0,
    parameter int  OUT_REG    = 0,
    localparam int DATA_WIDTH = BYTE_WIDTH * NUM_BYTES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_acc,
    input  logic [NUM_BYTES-1:0]  i_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic [DATA_WIDTH-1:0] o_q,
    output logic                  o_q_valid
);

    logic [MAX_DATA_W-1:0] w_merged_wide;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_do_read;
    logic                  w_unused;
    logic [DATA_WIDTH-1:0] r_q1;
    logic                  r_v1;

    // Select the word this access returns and whether it returns one at all.
    always_comb begin
        w_merged_wide = byte_merge(MAX_DATA_W'(i_rdata), MAX_DATA_W'(i_wdata),
                                   MAX_BYTES'(i_we), BYTE_WIDTH);
        if (RDW_MODE == int'(WRITE_FIRST)) begin
            w_rd_data = w_merged_wide[DATA_WIDTH-1:0];
        end else begin
            w_rd_data = i_rdata;
        end
        if ((RDW_MODE == int'(NO_CHANGE)) && (|i_we)) begin
            w_do_read = 1'b0;
        end else begin
            w_do_read = i_acc;
        end
    end

    assign w_unused = ^w_merged_wide[MAX_DATA_W-1:DATA_WIDTH];

    // First read stage: captures data at the access edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q1 <= {DATA_WIDTH{1'b0}};
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_do_read;
            if (w_do_read) begin
                r_q1 <= w_rd_data;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_q2;
        logic                  r_v2;

        // Optional output stage adding one cycle of latency.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_q2 <= {DATA_WIDTH{1'b0}};
                r_v2 <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_q2 <= r_q1;
                end
            end
        end

        assign o_q       = r_q2;
        assign o_q_valid = r_v2;
    end else begin : g_no_out_reg
        assign o_q       = r_q1;
        assign o_q_valid = r_v1;
    end

endmodule

// File: rtl/true_dpr_be.sv
// Single-clock true dual-port RAM with byte enables, port-A-wins write
// arbitration, collision flag and a post-reset memory clear sequencer.
module true_dpr_be
    import true_dpr_be_pkg::*;
#(
    parameter int  BYTE_WIDTH     = 8,
    parameter int  NUM_BYTES      = 4,
    parameter int  ADDR_WIDTH     = 8,
    parameter int  RDW_MODE       = 0,
    parameter int  OUT_REG        = 0,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int DATA_WIDTH     = BYTE_WIDTH * NUM_BYTES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_ready,
    input  logic                  i_a_en,
    input  logic [NUM_BYTES-1:0]  i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    output logic [DATA_WIDTH-1:0] o_a_q,
    output logic                  o_a_q_valid,
    input  logic                  i_b_en,
    input  logic [NUM_BYTES-1:0]  i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic [DATA_WIDTH-1:0] o_b_q,
    output logic                  o_b_q_valid,
    output logic                  o_collision
);

    localparam int     DEPTH     = 2 ** ADDR_WIDTH;
    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_ready;
    logic                  r_collision;
    logic                  w_a_acc;
    logic                  w_b_acc;
    logic                  w_clr_wr;
    logic                  w_collision_nxt;
    logic [DATA_WIDTH-1:0] w_a_old;
    logic [DATA_WIDTH-1:0] w_b_old;

    // Access qualification; the reset edge itself performs no access.
    always_comb begin
        w_a_acc         = i_a_en && r_ready && !i_rst;
        w_b_acc         = i_b_en && r_ready && !i_rst;
        w_clr_wr        = (r_state == CLEAR) && !i_rst;
        w_collision_nxt = w_a_acc && w_b_acc && (i_a_addr == i_b_addr)
                          && ((|i_a_we) || (|i_b_we));
        w_a_old         = r_mem[i_a_addr];
        w_b_old         = r_mem[i_b_addr];
    end

    // Next-state logic for the clear sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nxt = READY;
                end else begin
                    w_state_nxt = CLEAR;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = RST_STATE;
        endcase
    end

    // State register, clear counter, ready and collision flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RST_STATE;
            r_clr_cnt   <= {ADDR_WIDTH{1'b0}};
            r_ready     <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ready     <= (w_state_nxt == READY);
            r_collision <= w_collision_nxt;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Memory writes: B lanes first so that A overrides on shared bytes.
    always_ff @(posedge i_clk) begin
        if (w_clr_wr) begin
            r_mem[r_clr_cnt] <= {DATA_WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_b_acc && i_b_we[i]) begin
                    r_mem[i_b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_b_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_a_acc && i_a_we[i]) begin
                    r_mem[i_a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= i_a_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign o_ready     = r_ready;
    assign o_collision = r_collision;

    true_dpr_be_rd_port #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .NUM_BYTES  (NUM_BYTES),
        .RDW_MODE   (RDW_MODE),
        .OUT_REG    (OUT_REG)
    ) u_rd_a (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_acc     (w_a_acc),
        .i_we      (i_a_we),
        .i_wdata   (i_a_data),
        .i_rdata   (w_a_old),
        .o_q       (o_a_q),
        .o_q_valid (o_a_q_valid)
    );

    true_dpr_be_rd_port #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .NUM_BYTES  (NUM_BYTES),
        .RDW_MODE   (RDW_MODE),
        .OUT_REG    (OUT_REG)
    ) u_rd_b (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_acc     (w_b_acc),
        .i_we      (i_b_we),
        .i_wdata   (i_b_data),
        .i_rdata   (w_b_old),
        .o_q       (o_b_q),
        .o_q_valid (o_b_q_valid)
    );

endmodule

// File: tb/tb_true_dpr_be.sv
// Directed bench: three instances (READ_FIRST/no out reg, WRITE_FIRST/out reg,
// NO_CHANGE/no out reg) share one stimulus stream.
module tb_true_dpr_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, b_en;
    logic [3:0]  a_we, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;

    logic        rf_ready, wf_ready, nc_ready;
    logic [31:0] rf_a_q, rf_b_q, wf_a_q, wf_b_q, nc_a_q, nc_b_q;
    logic        rf_a_v, rf_b_v, wf_a_v, wf_b_v, nc_a_v, nc_b_v;
    logic        rf_col, wf_col, nc_col;

    int n_checks = 0;
    int n_errors = 0;
    int n;

    always #5 clk = ~clk;

    true_dpr_be #(.BYTE_WIDTH(8), .NUM_BYTES(4), .ADDR_WIDTH(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_rf (
        .i_clk(clk), .i_rst(rst), .o_ready(rf_ready),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_q(rf_a_q), .o_a_q_valid(rf_a_v),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_q(rf_b_q), .o_b_q_valid(rf_b_v),
        .o_collision(rf_col));

    true_dpr_be #(.BYTE_WIDTH(8), .NUM_BYTES(4), .ADDR_WIDTH(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_wf (
        .i_clk(clk), .i_rst(rst), .o_ready(wf_ready),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_q(wf_a_q), .o_a_q_valid(wf_a_v),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_q(wf_b_q), .o_b_q_valid(wf_b_v),
        .o_collision(wf_col));

    true_dpr_be #(.BYTE_WIDTH(8), .NUM_BYTES(4), .ADDR_WIDTH(4), .RDW_MODE(2), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_nc (
        .i_clk(clk), .i_rst(rst), .o_ready(nc_ready),
        .i_a_en(a_en), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_data(a_data), .o_a_q(nc_a_q), .o_a_q_valid(nc_a_v),
        .i_b_en(b_en), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_data(b_data), .o_b_q(nc_b_q), .o_b_q_valid(nc_b_v),
        .o_collision(nc_col));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_en = 1'b0; a_we = 4'b0000; a_addr = 4'd0; a_data = 32'h0000_0000;
        b_en = 1'b0; b_we = 4'b0000; b_addr = 4'd0; b_data = 32'h0000_0000;
    endtask

    task automatic acc_a(input logic [3:0] we, input logic [3:0] addr, input logic [31:0] data);
        a_en = 1'b1; a_we = we; a_addr = addr; a_data = data;
    endtask

    task automatic acc_b(input logic [3:0] we, input logic [3:0] addr, input logic [31:0] data);
        b_en = 1'b1; b_we = we; b_addr = addr; b_data = data;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        check("rst_ready", {31'd0, rf_ready}, 32'd0);
        check("rst_a_q", rf_a_q, 32'h0000_0000);
        check("rst_a_valid", {31'd0, rf_a_v}, 32'd0);
        check("rst_collision", {31'd0, rf_col}, 32'd0);
        check("rst_wf_b_q", wf_b_q, 32'h0000_0000);

        // Initial clear, then preload mem[5]
        rst = 1'b0;
        n = 0;
        while (!rf_ready && n < 40) begin tick(); n++; end
        check("clear_len_first", 32'(n), 32'd16);
        acc_a(4'b1111, 4'd5, 32'hDEAD_BEEF);
        tick();
        idle();

        // Scenario 1: reset pulse clears mem[5]
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s1_ready_low", {31'd0, rf_ready}, 32'd0);
        n = 0;
        while (!rf_ready && n < 40) begin tick(); n++; end
        check("s1_clear_len", 32'(n), 32'd16);
        acc_a(4'b0000, 4'd5, 32'h0000_0000);
        tick();
        idle();
        check("s1_rf_q", rf_a_q, 32'h0000_0000);
        check("s1_rf_valid", {31'd0, rf_a_v}, 32'd1);
        check("s1_wf_valid_early", {31'd0, wf_a_v}, 32'd0);
        tick();
        check("s1_wf_q", wf_a_q, 32'h0000_0000);
        check("s1_wf_valid", {31'd0, wf_a_v}, 32'd1);
        check("s1_rf_valid_drop", {31'd0, rf_a_v}, 32'd0);

        // Scenario 2: byte-lane write
        acc_a(4'b1111, 4'd3, 32'h1122_3344);
        tick();
        acc_a(4'b0101, 4'd3, 32'hAABB_CCDD);
        tick();
        check("s2_rf_pre_write", rf_a_q, 32'h1122_3344);
        check("s2_nc_no_valid", {31'd0, nc_a_v}, 32'd0);
        idle();
        acc_a(4'b0000, 4'd3, 32'h0000_0000);
        acc_b(4'b0000, 4'd3, 32'h0000_0000);
        tick();
        idle();
        check("s2_rf_a_q", rf_a_q, 32'h11BB_33DD);
        check("s2_rf_b_q", rf_b_q, 32'h11BB_33DD);
        check("s2_rf_b_valid", {31'd0, rf_b_v}, 32'd1);
        check("s2_nc_a_q", nc_a_q, 32'h11BB_33DD);

        // Scenario 3: same-port read-during-write
        acc_a(4'b1111, 4'd7, 32'h0102_0304);
        tick();
        acc_a(4'b1111, 4'd7, 32'hFFFF_FFFF);
        tick();
        idle();
        check("s3_rf_q", rf_a_q, 32'h0102_0304);
        check("s3_rf_valid", {31'd0, rf_a_v}, 32'd1);
        check("s3_nc_q_hold", nc_a_q, 32'h11BB_33DD);
        check("s3_nc_valid", {31'd0, nc_a_v}, 32'd0);
        tick();
        check("s3_wf_q", wf_a_q, 32'hFFFF_FFFF);
        check("s3_wf_valid", {31'd0, wf_a_v}, 32'd1);
        acc_a(4'b0000, 4'd7, 32'h0000_0000);
        tick();
        idle();
        check("s3_readback", rf_a_q, 32'hFFFF_FFFF);

        // Scenario 4: dual write collision, A wins shared byte
        acc_a(4'b0011, 4'd2, 32'hAAAA_AAAA);
        acc_b(4'b0110, 4'd2, 32'hBBBB_BBBB);
        tick();
        idle();
        check("s4_collision", {31'd0, rf_col}, 32'd1);
        tick();
        check("s4_collision_drop", {31'd0, rf_col}, 32'd0);
        acc_a(4'b0000, 4'd2, 32'h0000_0000);
        tick();
        idle();
        check("s4_merged", rf_a_q, 32'h00BB_AAAA);

        // Scenario 5: cross-port read while writing
        acc_a(4'b1111, 4'd9, 32'h1234_5678);
        tick();
        acc_a(4'b1111, 4'd9, 32'h0000_0000);
        acc_b(4'b0000, 4'd9, 32'h0000_0000);
        tick();
        idle();
        check("s5_rf_b_q", rf_b_q, 32'h1234_5678);
        check("s5_rf_b_valid", {31'd0, rf_b_v}, 32'd1);
        check("s5_collision", {31'd0, rf_col}, 32'd1);
        check("s5_nc_b_q", nc_b_q, 32'h1234_5678);
        acc_b(4'b0000, 4'd9, 32'h0000_0000);
        tick();
        idle();
        check("s5_rf_b_q2", rf_b_q, 32'h0000_0000);
        check("s5_collision2", {31'd0, rf_col}, 32'd0);
        acc_a(4'b0000, 4'd9, 32'h0000_0000);
        acc_b(4'b0000, 4'd9, 32'h0000_0000);
        tick();
        idle();
        check("read_read_no_col", {31'd0, rf_col}, 32'd0);

        // Address extremes on both ports
        acc_a(4'b1111, 4'd15, 32'hCAFE_F00D);
        acc_b(4'b1111, 4'd0, 32'h0BAD_C0DE);
        tick();
        idle();
        check("edge_no_col", {31'd0, rf_col}, 32'd0);
        acc_a(4'b0000, 4'd0, 32'h0000_0000);
        acc_b(4'b0000, 4'd15, 32'h0000_0000);
        tick();
        idle();
        check("edge_a_q", rf_a_q, 32'h0BAD_C0DE);
        check("edge_b_q", rf_b_q, 32'hCAFE_F00D);

        // Scenario 6: reset at clear count 6 restarts the clear
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("s6_ready_mid", {31'd0, rf_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_a(4'b1111, 4'd2, 32'h5555_5555);
        acc_b(4'b0000, 4'd2, 32'h0000_0000);
        n = 0;
        do begin
            tick();
            n++;
            check("s6_rf_a_valid", {31'd0, rf_a_v}, 32'd0);
            check("s6_rf_b_valid", {31'd0, rf_b_v}, 32'd0);
            check("s6_wf_a_valid", {31'd0, wf_a_v}, 32'd0);
        end while (!rf_ready && n < 40);
        idle();
        check("s6_clear_len", 32'(n), 32'd16);
        acc_a(4'b0000, 4'd2, 32'h0000_0000);
        tick();
        idle();
        check("s6_no_write", rf_a_q, 32'h0000_0000);
        check("s6_valid_after", {31'd0, rf_a_v}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
